// File: rtl/spi_dac_sequencer.sv
// spi_dac_sequencer: multi-channel SPI DAC update engine.
// Holds one shadow word per channel and serialises dirty words onto a shared
// SCLK/SDI bus (SPI mode 0, MSB first). Each channel has its own chip select.
// Every frame ends with an LDAC pulse.
// Optional build macro DAC_SYNC_LDAC_EN: frames run back to back while
// candidates remain, and a single LDAC pulse follows the last frame.
module spi_dac_sequencer #(
  parameter int unsigned NUM_CH  = 12,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned CH_W    = $clog2(NUM_CH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [DATA_W-1:0] wr_data,
  output logic              dac_sclk,
  output logic              dac_sdi,
  output logic [NUM_CH-1:0] dac_cs_n,
  output logic              dac_ldac_n,
  output logic              busy,
  output logic              wr_err,
  output logic [15:0]       frames_done
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [CH_W:0]    NumChL   = (CH_W+1)'(NUM_CH);
  localparam logic [CH_W-1:0]  LastCh   = CH_W'(NUM_CH - 1);
  localparam logic [CNT_W-1:0] CntLast  = CNT_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BitLast  = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    StIdle,
    StSelect,
    StShift,
    StDeselect,
    StLdac
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   shadow_q [NUM_CH];
  logic [NUM_CH-1:0]   dirty_q, dirty_d;
  logic [CH_W-1:0]     ptr_q, ptr_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic                phase_q, phase_d;   // 0: sclk high half, 1: sclk low half
  logic                wr_err_q, wr_err_d;
  logic [15:0]         frames_q, frames_d;

  logic                wr_in_range;
  logic [NUM_CH-1:0]   cand;
  logic                pick_valid;
  logic [CH_W-1:0]     pick_ch;
  logic                do_latch;
  logic                cnt_last;
  logic                bit_last;

  assign wr_in_range = ({1'b0, wr_ch} < NumChL);
  assign cand        = dirty_q & ch_en;
  assign cnt_last    = (cnt_q == CntLast);
  assign bit_last    = (bit_q == BitLast);
  assign wr_ready    = 1'b1;

  // Round-robin pick: lowest candidate at or after the pointer, with wrap.
  always_comb begin : rr_pick
    logic [CH_W:0] idx;
    idx        = '0;
    pick_valid = 1'b0;
    pick_ch    = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      idx = {1'b0, ptr_q} + (CH_W+1)'(i);
      if (idx >= NumChL) begin
        idx = idx - NumChL;
      end
      if (!pick_valid && cand[idx[CH_W-1:0]]) begin
        pick_valid = 1'b1;
        pick_ch    = idx[CH_W-1:0];
      end
    end
  end

  // Next-state logic for the frame sequencer, dirty bits and counters.
  always_comb begin
    state_d  = state_q;
    dirty_d  = dirty_q;
    ptr_d    = ptr_q;
    ch_d     = ch_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    phase_d  = phase_q;
    wr_err_d = wr_err_q;
    frames_d = frames_q;
    do_latch = 1'b0;

    case (state_q)
      StIdle: begin
        if (pick_valid) begin
          do_latch = 1'b1;
        end
      end
      StSelect: begin
        if (cnt_last) begin
          state_d = StShift;
          cnt_d   = '0;
          phase_d = 1'b0;
          bit_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StShift: begin
        if (cnt_last) begin
          cnt_d = '0;
          if (!phase_q) begin
            // Falling sclk edge: present the next bit.
            phase_d = 1'b1;
            shreg_d = shreg_q << 1;
          end else begin
            phase_d = 1'b0;
            if (bit_last) begin
              state_d = StDeselect;
            end else begin
              bit_d = bit_q + BIT_W'(1);
            end
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StDeselect: begin
        if (cnt_last) begin
          cnt_d    = '0;
          frames_d = frames_q + 16'd1;
`ifdef DAC_SYNC_LDAC_EN
          // Chain straight into the next frame; LDAC only once the queue is empty.
          if (pick_valid) begin
            do_latch = 1'b1;
          end else begin
            state_d = StLdac;
          end
`else
          state_d = StLdac;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StLdac: begin
        if (cnt_last) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase

    if (do_latch) begin
      state_d          = StSelect;
      cnt_d            = '0;
      ch_d             = pick_ch;
      shreg_d          = shadow_q[pick_ch];
      dirty_d[pick_ch] = 1'b0;
      ptr_d            = (pick_ch == LastCh) ? '0 : pick_ch + CH_W'(1);
    end

    // A same-cycle write re-arms dirty after the latch cleared it.
    if (wr_valid) begin
      if (wr_in_range) begin
        dirty_d[wr_ch] = 1'b1;
      end else begin
        wr_err_d = 1'b1;
      end
    end
  end

  // Sequencer state and datapath registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      dirty_q  <= '0;
      ptr_q    <= '0;
      ch_q     <= '0;
      shreg_q  <= '0;
      cnt_q    <= '0;
      bit_q    <= '0;
      phase_q  <= 1'b0;
      wr_err_q <= 1'b0;
      frames_q <= '0;
    end else begin
      state_q  <= state_d;
      dirty_q  <= dirty_d;
      ptr_q    <= ptr_d;
      ch_q     <= ch_d;
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      phase_q  <= phase_d;
      wr_err_q <= wr_err_d;
      frames_q <= frames_d;
    end
  end

  // Shadow word storage; out-of-range writes are dropped.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
        shadow_q[i] <= '0;
      end
    end else if (wr_valid && wr_in_range) begin
      shadow_q[wr_ch] <= wr_data;
    end
  end

  // Pin decode from the registered state.
  always_comb begin
    dac_sclk   = 1'b0;
    dac_sdi    = 1'b0;
    dac_cs_n   = '1;
    dac_ldac_n = 1'b1;
    case (state_q)
      StSelect: begin
        dac_cs_n[ch_q] = 1'b0;
        dac_sdi        = shreg_q[DATA_W-1];
      end
      StShift: begin
        dac_cs_n[ch_q] = 1'b0;
        dac_sdi        = shreg_q[DATA_W-1];
        dac_sclk       = ~phase_q;
      end
      StLdac: begin
        dac_ldac_n = 1'b0;
      end
      default: begin
      end
    endcase
  end

  assign busy        = (state_q != StIdle);
  assign wr_err      = wr_err_q;
  assign frames_done = frames_q;

endmodule

// File: doc/spi_dac_sequencer.md
Name: spi_dac_sequencer

Overview:
- Parametrised multi-channel SPI DAC update engine, the successor to hard-wired per-DAC enables and a free-running shared sclk.
- Holds one shadow word per channel and serialises changed words onto a shared SCLK/SDI bus, one channel at a time.
- Gives every channel its own active-low chip select, then issues an LDAC pulse.
- Sits between the UART-driven control logic and the DFB/DFBM/TEC DAC pins.

Parameters:
- NUM_CH, 12, number of DAC channels (2..32).
- DATA_W, 16, bits per DAC frame, sent MSB first.
- CLK_DIV, 2, clock cycles per SCLK half-period (>=1).
- CH_W, $clog2(NUM_CH), width of the channel index.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- ch_en  in  NUM_CH  per-channel enable mask; a disabled channel is never scanned.
- wr_valid  in  1  shadow write request.
- wr_ready  out  1  write accepted.
- wr_ch  in  CH_W  target channel of the write.
- wr_data  in  DATA_W  new DAC word.
- dac_sclk  out  1  shared SPI clock, mode 0.
- dac_sdi  out  1  shared serial data.
- dac_cs_n  out  NUM_CH  per-channel chip select, active low.
- dac_ldac_n  out  1  load-DAC strobe, active low.
- busy  out  1  high whenever the state is not IDLE.
- wr_err  out  1  sticky flag: a write to an out-of-range channel occurred.
- frames_done  out  16  count of completed frames; wraps 0xFFFF->0.

Behaviour:
- Reset (asynchronous, takes effect mid-frame too):
  - dac_sclk=0, dac_sdi=0, dac_cs_n=all 1, dac_ldac_n=1.
  - busy=0, wr_err=0, frames_done=0.
  - All shadow words 0, dirty bits 0, round-robin pointer 0, state IDLE.
- Write port:
  - wr_ready=1 in every cycle after reset.
  - On wr_valid with wr_ch<NUM_CH: shadow[wr_ch]<=wr_data and dirty[wr_ch]<=1.
  - On wr_valid with wr_ch>=NUM_CH: the write is dropped and wr_err<=1. wr_err is cleared only by reset.
  - Writes are accepted in any state. A frame in progress is not affected.
- Scheduling:
  - Candidates are channels with dirty & ch_en.
  - Round-robin: pick the lowest candidate index at or after the pointer, wrapping modulo NUM_CH.
  - After a channel is served, pointer <= served+1, with wrap.
- State machine:
  - IDLE:
    - Outputs held at their reset values.
    - If any candidate exists: latch shadow[ch] into the shift register, clear dirty[ch], go to SELECT.
    - A write to the same channel in that cycle wins: dirty stays 1, the old word is sent, and the new word is sent in a later frame.
  - SELECT: dac_cs_n[ch]=0, dac_sdi=MSB. Hold CLK_DIV cycles.
  - SHIFT:
    - DATA_W SCLK periods. Each period is sclk high for CLK_DIV cycles, then low for CLK_DIV cycles.
    - dac_sdi advances to the next bit on each falling edge.
    - After the final low half, go to DESELECT.
  - DESELECT: dac_cs_n all 1, sclk 0. Hold CLK_DIV cycles. frames_done increments on exit.
  - LDAC: dac_ldac_n=0 for CLK_DIV cycles, then go to IDLE.
- Frame timing:
  - Total length is CLK_DIV*(3+2*DATA_W) cycles.
  - With the defaults this is 70 cycles, and busy is high for exactly 70 cycles.
- Enable changes:
  - Changing ch_en mid-frame does not abort the frame.
  - Clearing a channel's enable leaves its dirty bit pending.
  - Re-enabling the channel schedules it.
- Only one dac_cs_n bit is ever low at a time. No cs bit is low while dac_ldac_n is low.

Optional Feature:
- Macro: DAC_SYNC_LDAC_EN.
- Defined:
  - After DESELECT, if another candidate exists, go straight to the next channel's latch/SELECT and skip LDAC.
  - LDAC is pulsed once, only when no candidates remain.
  - This gives a simultaneous update across all channels.
- Undefined: every frame is followed by its own LDAC pulse.

Test Plan:
- Reset, then write ch3=0xA5C3 with ch_en=all 1:
  - Only dac_cs_n[3] goes low.
  - 16 bits are sampled on the rising edges of sclk, giving 0xA5C3.
  - One LDAC pulse of 2 cycles, busy high for 70 cycles, frames_done=1.
- Write ch0=0x1111, ch5=0x2222 and ch11=0x3333 in the same idle period (pointer starts at 0):
  - Frames are served in the order 0, 5, 11.
  - Write ch0 again mid-frame of ch5: the order continues 11, then 0, giving round-robin fairness.
- Write ch2=0x0001 and ch2=0xFFFF in consecutive cycles, the second landing on the latch cycle:
  - Frame sends 0x0001, dirty stays set.
  - The next frame sends 0xFFFF, frames_done=2.
- Write ch4 with ch_en[4]=0:
  - No frame while disabled, busy stays 0.
  - Set ch_en[4]=1: the frame starts within 1 cycle.
- Write wr_ch=12 (NUM_CH=12): wr_err=1, no frame, and the shadow words are unchanged.
- Assert reset at cycle 20 of a frame:
  - Next edge shows dac_cs_n=all 1, sclk=0, busy=0.
  - After release, no frame occurs until a new write.
- With DAC_SYNC_LDAC_EN defined, write 3 channels:
  - 3 back-to-back frames.
  - Exactly one LDAC pulse, after the third frame.
